// File: rtl/snn_spike_count_decoder.sv
// ---------------------------------------------------------------------------
// snn_spike_count_decoder
//
// Rate-code readout for the output layer of the SNN core. Over a programmable
// window it counts spikes per output neuron in saturating counters. It then
// scans the counters one neuron per cycle to find the most active neuron
// (argmax) and presents the result on a valid/ready interface.
//
// Optional feature (compile-time macro): SNN_DECODE_EARLY_EXIT_EN
//   When defined, the window ends early in the cycle that any counter
//   reaches EXIT_THRESH, including that cycle's increment.
//   When undefined, the window always runs the full win_len cycles.
//
// Parameters
//   N_OUT        number of output neurons / classes
//   CNT_W        width of each saturating spike counter
//   WIN_W        width of the window-length input
//   EXIT_THRESH  early-exit spike count (only with the macro above)
//   CLS_W        width of class_id (derived)
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   start      begin a decode window (accepted only in IDLE with win_len!=0)
//   win_len    window length in cycles, sampled on the accepted start
//   spike_out  output-layer spikes, bit i = neuron i (sampled only in COUNT)
//   busy       high from accepted start until the result handshake completes
//   res_valid  result available
//   res_ready  consumer accepts result
//   class_id   index of the neuron with the highest count (lowest index on tie)
//   tie        another neuron's count equals the maximum
//   counts     flat counters, neuron i at [i*CNT_W +: CNT_W]
//   state_dbg  current FSM state (0 IDLE, 1 COUNT, 2 ARGMAX, 3 DONE)
//
// Result handshake: res_valid rises in DONE and stays high, with class_id,
// tie and counts frozen, until a clock edge where res_valid && res_ready.
// That edge completes the transfer: the block returns to IDLE and both
// res_valid and busy are low from the next cycle. res_valid never depends
// combinationally on res_ready.
// ---------------------------------------------------------------------------
module snn_spike_count_decoder #(
  parameter int N_OUT       = 2,
  parameter int CNT_W       = 8,
  parameter int WIN_W       = 16,
  parameter int EXIT_THRESH = 8,
  parameter int CLS_W       = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIN_W-1:0]       win_len,
  input  logic [N_OUT-1:0]       spike_out,
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CLS_W-1:0]       class_id,
  output logic                   tie,
  output logic [N_OUT*CNT_W-1:0] counts,
  output logic [1:0]             state_dbg
);

`ifdef SNN_DECODE_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    ARGMAX = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] cnt_q   [N_OUT];
  logic [CNT_W-1:0] cnt_inc [N_OUT];
  logic [CNT_W-1:0] max_q;
  logic [CLS_W-1:0] scan_q;
  logic [CLS_W-1:0] class_q;
  logic             tie_q;

  logic start_ok;
  logic thresh_hit;
  logic last_sample;
  logic scan_last;

  assign start_ok  = (state_q == IDLE) && start && (win_len != '0);
  assign scan_last = (scan_q == CLS_W'(N_OUT - 1));

  // Saturating increment: a counter at all-ones holds its value.
  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      cnt_inc[i] = cnt_q[i];
      if (spike_out[i] && (cnt_q[i] != '1)) begin
        cnt_inc[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Threshold is checked on the post-increment value so the window closes
  // in the same cycle the threshold is reached.
  always_comb begin
    thresh_hit = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (EARLY_EXIT && (int'(cnt_inc[i]) >= EXIT_THRESH)) begin
        thresh_hit = 1'b1;
      end
    end
  end

  assign last_sample = (win_q == WIN_W'(1)) || thresh_hit;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok)    state_d = COUNT;
      COUNT:   if (last_sample) state_d = ARGMAX;
      ARGMAX:  if (scan_last)   state_d = DONE;
      DONE:    if (res_ready)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      max_q   <= '0;
      scan_q  <= '0;
      class_q <= '0;
      tie_q   <= 1'b0;
      for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            win_q   <= win_len;
            max_q   <= '0;
            scan_q  <= '0;
            class_q <= '0;
            tie_q   <= 1'b0;
            for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
          end
        end
        COUNT: begin
          for (int i = 0; i < N_OUT; i++) cnt_q[i] <= cnt_inc[i];
          // Early exit can leave the window counter non-zero; clear it so
          // it always reads 0 outside COUNT.
          win_q <= last_sample ? '0 : (win_q - WIN_W'(1));
        end
        ARGMAX: begin
          // Strictly-greater compare keeps the lowest index on ties; a new
          // strict maximum invalidates any earlier tie.
          if (scan_q == '0) begin
            max_q   <= cnt_q[0];
            class_q <= '0;
            tie_q   <= 1'b0;
          end else if (cnt_q[scan_q] > max_q) begin
            max_q   <= cnt_q[scan_q];
            class_q <= scan_q;
            tie_q   <= 1'b0;
          end else if (cnt_q[scan_q] == max_q) begin
            tie_q   <= 1'b1;
          end
          if (!scan_last) scan_q <= scan_q + CLS_W'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_counts
    assign counts[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign class_id  = class_q;
  assign tie       = tie_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_snn_spike_count_decoder.sv
// ---------------------------------------------------------------------------
// tb_snn_spike_count_decoder
//
// Directed bench for snn_spike_count_decoder. Three instances share clk and
// rst_n:
//   index 0: CNT_W=8, EXIT_THRESH=200 (threshold never reached here)
//   index 1: CNT_W=4, EXIT_THRESH=15  (counter saturation)
//   index 2: CNT_W=8, EXIT_THRESH=4   (early-exit window)
// Expected values are hand-computed per vector; those that depend on
// SNN_DECODE_EARLY_EXIT_EN are selected with the same macro.
// ---------------------------------------------------------------------------
module tb_snn_spike_count_decoder;

  localparam int N_OUT = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // per-instance stimulus and observation
  logic        start_v  [3];
  logic [15:0] win_v    [3];
  logic [1:0]  spk_v    [3];
  logic        rdy_v    [3];
  logic        busy_v   [3];
  logic        vld_v    [3];
  logic        cls_v    [3];
  logic        tie_v    [3];
  logic [1:0]  sd_v     [3];
  logic [7:0]  c0_v     [3];
  logic [7:0]  c1_v     [3];

  logic [15:0] counts_a;
  logic [7:0]  counts_b;
  logic [15:0] counts_c;

  always_comb begin
    c0_v[0] = counts_a[7:0];
    c1_v[0] = counts_a[15:8];
    c0_v[1] = {4'b0, counts_b[3:0]};
    c1_v[1] = {4'b0, counts_b[7:4]};
    c0_v[2] = counts_c[7:0];
    c1_v[2] = counts_c[15:8];
  end

  snn_spike_count_decoder #(.N_OUT(N_OUT), .CNT_W(8), .WIN_W(16), .EXIT_THRESH(200)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .win_len(win_v[0]),
    .spike_out(spk_v[0]), .busy(busy_v[0]), .res_valid(vld_v[0]),
    .res_ready(rdy_v[0]), .class_id(cls_v[0]), .tie(tie_v[0]),
    .counts(counts_a), .state_dbg(sd_v[0])
  );

  snn_spike_count_decoder #(.N_OUT(N_OUT), .CNT_W(4), .WIN_W(16), .EXIT_THRESH(15)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .win_len(win_v[1]),
    .spike_out(spk_v[1]), .busy(busy_v[1]), .res_valid(vld_v[1]),
    .res_ready(rdy_v[1]), .class_id(cls_v[1]), .tie(tie_v[1]),
    .counts(counts_b), .state_dbg(sd_v[1])
  );

  snn_spike_count_decoder #(.N_OUT(N_OUT), .CNT_W(8), .WIN_W(16), .EXIT_THRESH(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .win_len(win_v[2]),
    .spike_out(spk_v[2]), .busy(busy_v[2]), .res_valid(vld_v[2]),
    .res_ready(rdy_v[2]), .class_id(cls_v[2]), .tie(tie_v[2]),
    .counts(counts_c), .state_dbg(sd_v[2])
  );

  // scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Spike pattern for sample k (k=1 is the first COUNT cycle). Patterns keep
  // driving after the window so ignored samples would corrupt the counts.
  function automatic logic [1:0] pat(input int mode, input int k);
    case (mode)
      0:       return {logic'(k % 2 == 0), 1'b1};               // n0 always, n1 every 2nd
      1:       return (k <= 3) ? 2'b01 : (k <= 6) ? 2'b10 : 2'b11; // 3 and 3 in 6 cycles
      2:       return 2'b10;                                       // n1 constant
      3:       return 2'b00;                                       // silent
      4:       return {1'b1, logic'(k % 2 == 1)};                 // n1 always, n0 odd cycles
      default: return 2'b00;
    endcase
  endfunction

  // Drive one window, wait for the result, check it, optionally hold
  // res_ready low for `hold` cycles (with a start pulse), then handshake.
  task automatic do_window(input int sel, input int wl, input int mode, input int hold,
                           input int e_c0, input int e_c1, input int e_cls,
                           input int e_tie, input int e_lat, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    start_v[sel] = 1'b1;
    win_v[sel]   = 16'(wl);
    spk_v[sel]   = 2'b00;
    @(posedge clk); #1;
    check({tag, "_busy_on"}, busy_v[sel], 1);
    for (int p = 1; p <= 200 && lat == 0; p++) begin
      @(negedge clk);
      start_v[sel] = 1'b0;
      spk_v[sel]   = pat(mode, p);
      @(posedge clk); #1;
      if (vld_v[sel]) lat = p + 1;
    end
    check({tag, "_latency"}, lat, e_lat);
    check({tag, "_c0"}, c0_v[sel], e_c0);
    check({tag, "_c1"}, c1_v[sel], e_c1);
    check({tag, "_class"}, cls_v[sel], e_cls);
    check({tag, "_tie"}, tie_v[sel], e_tie);
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      start_v[sel] = (h == 2);
      win_v[sel]   = 16'd3;
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, vld_v[sel], 1);
      check({tag, "_hold_busy"}, busy_v[sel], 1);
      check({tag, "_hold_c1"}, c1_v[sel], e_c1);
      check({tag, "_hold_class"}, cls_v[sel], e_cls);
    end
    @(negedge clk);
    start_v[sel] = 1'b0;
    spk_v[sel]   = 2'b00;
    rdy_v[sel]   = 1'b1;
    @(posedge clk); #1;
    rdy_v[sel] = 1'b0;
    check({tag, "_hs_valid"}, vld_v[sel], 0);
    check({tag, "_hs_busy"}, busy_v[sel], 0);
    check({tag, "_hs_state"}, sd_v[sel], 0);
    check({tag, "_idle_c0"}, c0_v[sel], e_c0);
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      win_v[i]   = '0;
      spk_v[i]   = '0;
      rdy_v[i]   = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_v[0], 0);
    check("rst_valid", vld_v[0], 0);
    check("rst_class", cls_v[0], 0);
    check("rst_tie", tie_v[0], 0);
    check("rst_counts", counts_a, 0);
    check("rst_state", sd_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 10/5 counts, held in DONE for 5 cycles with a start pulse
    do_window(0, 10, 0, 5, 10, 5, 0, 0, 13, "t1");
    // 3/3 tie, lowest index wins
    do_window(0, 6, 1, 0, 3, 3, 0, 1, 9, "t2");
    // all-zero counts -> class 0 with tie
    do_window(0, 3, 3, 0, 0, 0, 0, 1, 6, "zero");
    // later neuron strictly greater
    do_window(0, 7, 4, 0, 4, 7, 1, 0, 10, "n1win");

    // 4-bit counters saturate at 15
`ifdef SNN_DECODE_EARLY_EXIT_EN
    do_window(1, 20, 2, 0, 0, 15, 1, 0, 18, "sat");
`else
    do_window(1, 20, 2, 0, 0, 15, 1, 0, 23, "sat");
`endif

    // early exit at 4 spikes vs full 50-cycle window
`ifdef SNN_DECODE_EARLY_EXIT_EN
    do_window(2, 50, 2, 0, 0, 4, 1, 0, 7, "exit");
`else
    do_window(2, 50, 2, 0, 0, 50, 1, 0, 53, "exit");
`endif

    // start with win_len == 0 is ignored
    @(negedge clk);
    start_v[0] = 1'b1;
    win_v[0]   = 16'd0;
    @(posedge clk); #1;
    check("wl0_busy", busy_v[0], 0);
    check("wl0_state", sd_v[0], 0);
    @(negedge clk);
    start_v[0] = 1'b0;

    // reset in the middle of a window
    start_v[0] = 1'b1;
    win_v[0]   = 16'd10;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    spk_v[0]   = 2'b11;
    repeat (4) @(posedge clk);
    #2;
    check("mid_busy_pre", busy_v[0], 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy_v[0], 0);
    check("mid_rst_valid", vld_v[0], 0);
    check("mid_rst_counts", counts_a, 0);
    check("mid_rst_class", cls_v[0], 0);
    check("mid_rst_tie", tie_v[0], 0);
    check("mid_rst_state", sd_v[0], 0);
    @(negedge clk);
    spk_v[0] = 2'b00;
    rst_n    = 1'b1;

    // normal operation after the abort
    do_window(0, 7, 4, 0, 4, 7, 1, 0, 10, "recover");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
